// File: rtl/wave_pc_pkg.sv
// Shared definitions for the wave PC table and issue scheduler:
// update opcode encodings and the wave-id width helper.
package wave_pc_pkg;

    localparam logic [1:0] OP_INC    = 2'd0;
    localparam logic [1:0] OP_BR_REL = 2'd1;
    localparam logic [1:0] OP_BR_ABS = 2'd2;
    localparam logic [1:0] OP_HALT   = 2'd3;

    // A single-context SIMD still needs a one-bit wave id port.
    function automatic int calcWidWidth(input int numWaves);
        return (numWaves <= 1) ? 1 : $clog2(numWaves);
    endfunction

endpackage

// File: rtl/wave_pc_sched_rr_arbiter.sv
// Combinational round-robin arbiter: returns the first asserted request
// at or after the pointer, wrapping from the top index back to zero.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         grant_valid_o,
    output logic [W-1:0] grant_idx_o
);

    int          cand;
    logic [W-1:0] candIdx;

    // Walk all N slots starting at the pointer and latch the first hit.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        cand          = 0;
        candIdx       = '0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr_i) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            candIdx = W'(cand);
            if (!grant_valid_o && req_i[candIdx]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = candIdx;
            end
        end
    end

endmodule

// File: rtl/wave_pc_sched.sv
// Per-SIMD program-counter table with a round-robin wave issue scheduler.
// Accepts wave dispatch, applies retire-time PC updates and presents one
// eligible wave's PC per cycle to the fetch stage with one cycle latency.
module wave_pc_sched
    import wave_pc_pkg::*;
#(
    parameter int PC_WIDTH       = 32,
    parameter int WAVES_PER_SIMD = 4,
    parameter int OFFSET_WIDTH   = 16,
    localparam int WID_W         = calcWidWidth(WAVES_PER_SIMD)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      dispatch_valid,
    input  logic [WID_W-1:0]          dispatch_wave_id,
    input  logic [PC_WIDTH-1:0]       dispatch_start_pc,
    input  logic                      update_valid,
    input  logic [WID_W-1:0]          update_wave_id,
    input  logic [1:0]                update_op,
    input  logic                      branch_taken,
    input  logic [OFFSET_WIDTH-1:0]   branch_offset,
    input  logic [PC_WIDTH-1:0]       branch_target,
    input  logic                      issue_ready,
    output logic                      issue_valid,
    output logic [WID_W-1:0]          issue_wave_id,
    output logic [PC_WIDTH-1:0]       issue_pc,
    output logic [WAVES_PER_SIMD-1:0] wave_active,
    output logic [WAVES_PER_SIMD-1:0] wave_done,
    output logic                      all_done,
    output logic                      dispatch_err
);

    localparam logic [PC_WIDTH-1:0] PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WID_W-1:0]    WID_TOP = WID_W'(WAVES_PER_SIMD - 1);
    localparam logic [WID_W-1:0]    WID_ONE = WID_W'(1);

    logic [PC_WIDTH-1:0]       pc_q [WAVES_PER_SIMD];
    logic [PC_WIDTH-1:0]       pc_d [WAVES_PER_SIMD];
    logic [WAVES_PER_SIMD-1:0] active_q, active_d;
    logic [WAVES_PER_SIMD-1:0] done_q, done_d;
    logic [WAVES_PER_SIMD-1:0] inFlight_q, inFlight_d;
    logic [WID_W-1:0]          rrPtr_q, rrPtr_d;
    logic                      issueValid_q, issueValid_d;
    logic [WID_W-1:0]          issueWaveId_q, issueWaveId_d;
    logic [PC_WIDTH-1:0]       issuePc_q, issuePc_d;
    logic                      dispatchErr_q, dispatchErr_d;

    logic [WAVES_PER_SIMD-1:0] eligible;
    logic                      grantValid;
    logic [WID_W-1:0]          grantIdx;
    logic                      updIdOk;
    logic                      dispIdOk;
    logic                      updHit;
    logic [PC_WIDTH-1:0]       updPcInc;
    logic [PC_WIDTH-1:0]       offsetExt;

    // Eligibility always reflects the state before this cycle's updates,
    // so a retiring wave cannot be reissued in the same cycle.
    assign eligible = active_q & ~inFlight_q;

    rr_arbiter #(
        .N (WAVES_PER_SIMD),
        .W (WID_W)
    ) u_arbiter (
        .req_i         (eligible),
        .ptr_i         (rrPtr_q),
        .grant_valid_o (grantValid),
        .grant_idx_o   (grantIdx)
    );

    // Ids beyond the context count only exist when the count is not a power of two.
    assign updIdOk  = int'(update_wave_id) < WAVES_PER_SIMD;
    assign dispIdOk = int'(dispatch_wave_id) < WAVES_PER_SIMD;
    assign updHit   = update_valid && updIdOk &&
                      active_q[update_wave_id] && inFlight_q[update_wave_id];

    // Offset is sign-extended so negative branches wrap modulo the PC width.
    assign offsetExt = {{(PC_WIDTH-OFFSET_WIDTH){branch_offset[OFFSET_WIDTH-1]}}, branch_offset};
    assign updPcInc  = pc_q[update_wave_id] + PC_ONE;

    // Next-state: apply update first, then dispatch (which sees a same-cycle
    // HALT as freeing the slot), then the issue grant from pre-update state.
    always_comb begin
        pc_d          = pc_q;
        active_d      = active_q;
        done_d        = done_q;
        inFlight_d    = inFlight_q;
        rrPtr_d       = rrPtr_q;
        issueValid_d  = 1'b0;
        issueWaveId_d = issueWaveId_q;
        issuePc_d     = issuePc_q;
        dispatchErr_d = dispatchErr_q;

        if (updHit) begin
            inFlight_d[update_wave_id] = 1'b0;
            case (update_op)
                OP_INC: begin
                    pc_d[update_wave_id] = updPcInc;
                end
                OP_BR_REL: begin
                    pc_d[update_wave_id] = branch_taken ?
                        (pc_q[update_wave_id] + offsetExt) : updPcInc;
                end
                OP_BR_ABS: begin
                    pc_d[update_wave_id] = branch_taken ? branch_target : updPcInc;
                end
                OP_HALT: begin
                    active_d[update_wave_id] = 1'b0;
                    done_d[update_wave_id]   = 1'b1;
                end
            endcase
        end

        if (dispatch_valid && dispIdOk) begin
            if (active_d[dispatch_wave_id]) begin
                dispatchErr_d = 1'b1;
            end else begin
                pc_d[dispatch_wave_id]       = dispatch_start_pc;
                active_d[dispatch_wave_id]   = 1'b1;
                done_d[dispatch_wave_id]     = 1'b0;
                inFlight_d[dispatch_wave_id] = 1'b0;
            end
        end

        if (issue_ready && grantValid) begin
            issueValid_d         = 1'b1;
            issueWaveId_d        = grantIdx;
            issuePc_d            = pc_q[grantIdx];
            inFlight_d[grantIdx] = 1'b1;
            rrPtr_d              = (grantIdx == WID_TOP) ? '0 : (grantIdx + WID_ONE);
        end
    end

    // State registers with asynchronous clear of every context and output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WAVES_PER_SIMD; i++) begin
                pc_q[i] <= '0;
            end
            active_q      <= '0;
            done_q        <= '0;
            inFlight_q    <= '0;
            rrPtr_q       <= '0;
            issueValid_q  <= 1'b0;
            issueWaveId_q <= '0;
            issuePc_q     <= '0;
            dispatchErr_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            active_q      <= active_d;
            done_q        <= done_d;
            inFlight_q    <= inFlight_d;
            rrPtr_q       <= rrPtr_d;
            issueValid_q  <= issueValid_d;
            issueWaveId_q <= issueWaveId_d;
            issuePc_q     <= issuePc_d;
            dispatchErr_q <= dispatchErr_d;
        end
    end

    assign issue_valid   = issueValid_q;
    assign issue_wave_id = issueWaveId_q;
    assign issue_pc      = issuePc_q;
    assign wave_active   = active_q;
    assign wave_done     = done_q;
    assign all_done      = ~|active_q && |done_q;
    assign dispatch_err  = dispatchErr_q;

endmodule

// File: tb/tb_wave_pc_sched.sv
// Self-checking bench for wave_pc_sched: directed scenarios followed by
// randomized traffic, all compared against a behavioural wave-table model.
module tb_wave_pc_sched;

    localparam int N   = 4;
    localparam int PCW = 32;
    localparam int OFW = 16;
    localparam int WW  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           dispatch_valid;
    logic [WW-1:0]  dispatch_wave_id;
    logic [PCW-1:0] dispatch_start_pc;
    logic           update_valid;
    logic [WW-1:0]  update_wave_id;
    logic [1:0]     update_op;
    logic           branch_taken;
    logic [OFW-1:0] branch_offset;
    logic [PCW-1:0] branch_target;
    logic           issue_ready;
    logic           issue_valid;
    logic [WW-1:0]  issue_wave_id;
    logic [PCW-1:0] issue_pc;
    logic [N-1:0]   wave_active;
    logic [N-1:0]   wave_done;
    logic           all_done;
    logic           dispatch_err;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: one record per wave context plus scheduler state.
    bit [31:0] mPc   [N];
    bit        mAct  [N];
    bit        mDone [N];
    bit        mFly  [N];
    int        mPtr;
    bit        mIssV;
    int        mIssId;
    bit [31:0] mIssPc;
    bit        mErr;

    always #5 clk = ~clk;

    wave_pc_sched #(
        .PC_WIDTH       (PCW),
        .WAVES_PER_SIMD (N),
        .OFFSET_WIDTH   (OFW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .dispatch_valid    (dispatch_valid),
        .dispatch_wave_id  (dispatch_wave_id),
        .dispatch_start_pc (dispatch_start_pc),
        .update_valid      (update_valid),
        .update_wave_id    (update_wave_id),
        .update_op         (update_op),
        .branch_taken      (branch_taken),
        .branch_offset     (branch_offset),
        .branch_target     (branch_target),
        .issue_ready       (issue_ready),
        .issue_valid       (issue_valid),
        .issue_wave_id     (issue_wave_id),
        .issue_pc          (issue_pc),
        .wave_active       (wave_active),
        .wave_done         (wave_done),
        .all_done          (all_done),
        .dispatch_err      (dispatch_err)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            mPc[i] = 0; mAct[i] = 0; mDone[i] = 0; mFly[i] = 0;
        end
        mPtr = 0; mIssV = 0; mIssId = 0; mIssPc = 0; mErr = 0;
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic modelStep();
        int        grant = -1;
        bit [31:0] grantPc = 0;
        int        u = int'(update_wave_id);
        int        d = int'(dispatch_wave_id);
        int        off;
        for (int k = 0; k < N; k++) begin
            int w = (mPtr + k) % N;
            if (grant < 0 && mAct[w] && !mFly[w]) begin
                grant = w;
                grantPc = mPc[w];
            end
        end
        if (update_valid && mAct[u] && mFly[u]) begin
            mFly[u] = 0;
            off = $signed(branch_offset);
            case (update_op)
                2'd0: mPc[u] = mPc[u] + 1;
                2'd1: mPc[u] = branch_taken ? mPc[u] + off : mPc[u] + 1;
                2'd2: mPc[u] = branch_taken ? branch_target : mPc[u] + 1;
                default: begin mAct[u] = 0; mDone[u] = 1; end
            endcase
        end
        if (dispatch_valid) begin
            if (mAct[d]) mErr = 1;
            else begin
                mPc[d] = dispatch_start_pc; mAct[d] = 1; mDone[d] = 0; mFly[d] = 0;
            end
        end
        if (issue_ready && grant >= 0) begin
            mIssV = 1; mIssId = grant; mIssPc = grantPc;
            mFly[grant] = 1;
            mPtr = (grant + 1) % N;
        end else begin
            mIssV = 0;
        end
    endtask

    task automatic checkModel();
        logic [N-1:0] expAct, expDone;
        bit anyAct = 0, anyDone = 0;
        for (int i = 0; i < N; i++) begin
            expAct[i] = mAct[i]; expDone[i] = mDone[i];
            anyAct |= mAct[i]; anyDone |= mDone[i];
        end
        checkOutput("issue_valid", 64'(issue_valid), 64'(mIssV));
        checkOutput("issue_wave_id", 64'(issue_wave_id), 64'(mIssId));
        checkOutput("issue_pc", 64'(issue_pc), 64'(mIssPc));
        checkOutput("wave_active", 64'(wave_active), 64'(expAct));
        checkOutput("wave_done", 64'(wave_done), 64'(expDone));
        checkOutput("all_done", 64'(all_done), 64'(!anyAct && anyDone));
        checkOutput("dispatch_err", 64'(dispatch_err), 64'(mErr));
    endtask

    // Drive one cycle of inputs, step the model and compare after the edge.
    task automatic applyStimulus(input bit dv, input int did, input bit [31:0] dpc,
                                 input bit uv, input int uid, input bit [1:0] op,
                                 input bit tk, input bit [15:0] off, input bit [31:0] tgt,
                                 input bit rdy);
        dispatch_valid    = dv;
        dispatch_wave_id  = WW'(did);
        dispatch_start_pc = dpc;
        update_valid      = uv;
        update_wave_id    = WW'(uid);
        update_op         = op;
        branch_taken      = tk;
        branch_offset     = off;
        branch_target     = tgt;
        issue_ready       = rdy;
        modelStep();
        @(posedge clk);
        #1;
        checkModel();
    endtask

    task automatic idle(input bit rdy);
        applyStimulus(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, rdy);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1;
        modelReset();
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        int order[$];
        int fly[$];
        rst = 1;
        applyStimulus(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
        modelReset();
        #1;
        checkModel();
        @(negedge clk);
        rst = 0;

        // Two dispatches, then in-order issue and starvation once both are in flight.
        applyStimulus(1, 0, 32'h100, 0, 0, 2'd0, 0, 0, 0, 1);
        checkOutput("no_issue_same_cycle", 64'(issue_valid), 64'd0);
        applyStimulus(1, 2, 32'h200, 0, 0, 2'd0, 0, 0, 0, 1);
        checkOutput("first_issue_pc", 64'(issue_pc), 64'h100);
        idle(1);
        checkOutput("second_issue_id", 64'(issue_wave_id), 64'd2);
        checkOutput("second_issue_pc", 64'(issue_pc), 64'h200);
        idle(1);
        checkOutput("none_eligible", 64'(issue_valid), 64'd0);

        // Branch sequence on wave 0.
        applyStimulus(0, 0, 0, 1, 0, 2'd1, 1, 16'hFFFC, 0, 1);
        idle(1);
        checkOutput("br_rel_neg", 64'(issue_pc), 64'hFC);
        applyStimulus(0, 0, 0, 1, 0, 2'd2, 0, 0, 32'h40, 1);
        idle(1);
        checkOutput("br_abs_not_taken", 64'(issue_pc), 64'hFD);
        applyStimulus(0, 0, 0, 1, 0, 2'd2, 1, 0, 32'h40, 1);
        idle(1);
        checkOutput("br_abs_taken", 64'(issue_pc), 64'h40);

        // PC wrap on increment.
        applyStimulus(1, 1, 32'hFFFF_FFFF, 0, 0, 2'd0, 0, 0, 0, 1);
        idle(1);
        checkOutput("wrap_start", 64'(issue_pc), 64'hFFFF_FFFF);
        applyStimulus(0, 0, 0, 1, 1, 2'd0, 0, 0, 0, 1);
        idle(1);
        checkOutput("wrap_pc", 64'(issue_pc), 64'h0);
        checkOutput("wrap_valid", 64'(issue_valid), 64'd1);

        // Asynchronous reset while an issue is presented.
        #2;
        rst = 1;
        modelReset();
        #1;
        checkModel();
        checkOutput("async_rst_valid", 64'(issue_valid), 64'd0);
        @(negedge clk);
        rst = 0;

        // HALT the only wave, then update an inactive wave, then redispatch.
        applyStimulus(1, 3, 32'h10, 0, 0, 2'd0, 0, 0, 0, 1);
        idle(1);
        applyStimulus(0, 0, 0, 1, 3, 2'd3, 0, 0, 0, 1);
        checkOutput("halt_all_done", 64'(all_done), 64'd1);
        checkOutput("halt_done_bit", 64'(wave_done), 64'b1000);
        applyStimulus(0, 0, 0, 1, 3, 2'd2, 1, 0, 32'h55, 1);
        applyStimulus(0, 0, 0, 1, 2, 2'd0, 0, 0, 0, 1);
        checkOutput("inactive_update_active", 64'(wave_active), 64'd0);
        applyStimulus(1, 3, 32'h20, 0, 0, 2'd0, 0, 0, 0, 1);
        checkOutput("redispatch_all_done", 64'(all_done), 64'd0);

        // Fairness with all four waves eligible and immediate INC retires.
        doReset();
        for (int w = 0; w < N; w++) applyStimulus(1, w, 32'(w * 32'h1000), 0, 0, 2'd0, 0, 0, 0, 0);
        idle(1);
        if (issue_valid) order.push_back(int'(issue_wave_id));
        for (int c = 0; c < 4; c++) begin
            applyStimulus(0, 0, 0, 1, int'(issue_wave_id), 2'd0, 0, 0, 0, 1);
            if (issue_valid) order.push_back(int'(issue_wave_id));
        end
        checkOutput("rr_count", 64'(order.size()), 64'd5);
        for (int i = 0; i < order.size() && i < 5; i++) checkOutput("rr_order", 64'(order[i]), 64'(i % 4));

        // Dispatch to an active wave: error flag, PC untouched.
        applyStimulus(1, 1, 32'h999, 0, 0, 2'd0, 0, 0, 0, 0);
        checkOutput("dispatch_err", 64'(dispatch_err), 64'd1);
        idle(1);
        checkOutput("err_pc_kept", 64'(issue_pc), 64'h1001);

        // Randomized traffic, updates biased towards in-flight waves.
        doReset();
        for (int c = 0; c < 3000; c++) begin
            bit dv = ($urandom_range(0, 99) < 20);
            bit uv = ($urandom_range(0, 99) < 60);
            int uid = $urandom_range(0, N - 1);
            bit [31:0] dpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
            fly.delete();
            for (int i = 0; i < N; i++) if (mFly[i]) fly.push_back(i);
            if (fly.size() > 0 && $urandom_range(0, 9) < 8) uid = fly[$urandom_range(0, fly.size() - 1)];
            applyStimulus(dv, $urandom_range(0, N - 1), dpc, uv, uid, 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 16'($urandom), $urandom,
                          $urandom_range(0, 3) != 0);
            if (c % 1000 == 999) doReset();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
